dummy_accelerator_sched: RTL and testbench

Round-robin scheduler that shares one dummy accelerator datapath between `NUM_REQ` requesters. It grants one request at a time and latches that request's operand and immediate. It then sequences the datapath for a programmable number of cycles set by the immediate, and returns the captured result to the granted requester over a valid/ready response channel tagged with the requester index. It sits between the requester-side issue ports and the accelerator datapath, replacing per-requester control units.

---
 rtl/dummy_accelerator_sched.sv | 143 ++++++++++++++
 tb/tb_dummy_accelerator_sched.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dummy_accelerator_sched.sv
// Round-robin scheduler sharing one accelerator datapath between NUM_REQ requesters.
// Grants one request at a time, sequences the datapath for imm+1 cycles and returns a tagged response.
module dummy_accelerator_sched #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ*IMM_W-1:0]  req_imm_i,
  output logic                      acc_start_o,
  output logic [DATA_W-1:0]         acc_data_o,
  output logic [IMM_W-1:0]          acc_imm_o,
  input  logic [DATA_W-1:0]         acc_result_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic [ID_W-1:0]           rsp_id_o,
  output logic                      busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e            state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   id_q;
  logic [DATA_W-1:0] data_q;
  logic [IMM_W-1:0]  imm_q;
  logic [DATA_W-1:0] result_q;
  logic [IMM_W-1:0]  cnt_q;
  logic              start_q;

  logic [DATA_W-1:0] req_data_arr [NUM_REQ];
  logic [IMM_W-1:0]  req_imm_arr  [NUM_REQ];
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W:0]     ptr_sum;
  logic [ID_W-1:0]   ptr_next;
  logic              handshake;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_data_arr[k] = req_data_i[k*DATA_W +: DATA_W];
    assign req_imm_arr[k]  = req_imm_i[k*IMM_W +: IMM_W];
  end

  // Search from the pointer upward; the extra index bit lets the sum wrap for any NUM_REQ.
  always_comb begin : grant_search
    logic [ID_W:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_REQ)) begin
        idx = idx - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid_i[idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_sum  = {1'b0, grant_idx} + (ID_W+1)'(1);
    ptr_next = (ptr_sum >= (ID_W+1)'(NUM_REQ)) ? '0 : ptr_sum[ID_W-1:0];
  end

  assign handshake = (state_q == IDLE) && !flush_i && grant_found;

  always_comb begin
    req_ready_o = '0;
    if (handshake) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  // Flush overrides every transition, including a response handshake in RESP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      data_q   <= '0;
      imm_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      start_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (flush_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (handshake) begin
              data_q  <= req_data_arr[grant_idx];
              imm_q   <= req_imm_arr[grant_idx];
              cnt_q   <= req_imm_arr[grant_idx];
              id_q    <= grant_idx;
              ptr_q   <= ptr_next;
              start_q <= 1'b1;
              state_q <= BUSY;
            end
          end
          BUSY: begin
            if (cnt_q == '0) begin
              result_q <= acc_result_i;
              state_q  <= RESP;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          RESP: begin
            if (rsp_ready_i) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign acc_start_o = start_q;
  assign acc_data_o  = data_q;
  assign acc_imm_o   = imm_q;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_data_o  = result_q;
  assign rsp_id_o    = id_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_dummy_accelerator_sched.sv
// Scoreboard bench for dummy_accelerator_sched: directed requests, a cycle-timed reference
// of grant/busy/response timing, and a queue of expected tagged responses.
module tb_dummy_accelerator_sched;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int IMM_W   = 3;
  localparam int ID_W    = 1;

  logic                      clk_i;
  logic                      rst_ni;
  logic                      flush_i;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ*IMM_W-1:0]  req_imm_i;
  logic                      acc_start_o;
  logic [DATA_W-1:0]         acc_data_o;
  logic [IMM_W-1:0]          acc_imm_o;
  logic [DATA_W-1:0]         acc_result_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [DATA_W-1:0]         rsp_data_o;
  logic [ID_W-1:0]           rsp_id_o;
  logic                      busy_o;

  typedef struct {
    int          id;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    int id;
    int c;
  } grant_t;

  rsp_t   sb[$];
  grant_t hs_log[$];

  int          n_checks;
  int          n_errors;
  int          cyc;
  logic [31:0] tb_data [NUM_REQ];
  logic [2:0]  tb_imm  [NUM_REQ];
  int          issued  [NUM_REQ];
  int          done    [NUM_REQ];
  logic [NUM_REQ-1:0] hs_now;

  bit          m_active;
  int          m_busy_from;
  int          m_rsp_from;
  int          m_ptr;
  logic [31:0] m_data;
  logic [2:0]  m_imm;
  int          g;
  int          kk;
  logic [NUM_REQ-1:0] exp_ready;

  dummy_accelerator_sched #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_data_i  (req_data_i),
    .req_imm_i   (req_imm_i),
    .acc_start_o (acc_start_o),
    .acc_data_o  (acc_data_o),
    .acc_imm_o   (acc_imm_o),
    .acc_result_i(acc_result_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_id_o    (rsp_id_o),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Datapath stand-in: result changes every cycle so the capture cycle is observable.
  assign acc_result_i = ~acc_data_o + 32'(cyc);

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_valid_i[k]                    = (issued[k] != done[k]);
      req_data_i[k*DATA_W +: DATA_W]    = tb_data[k];
      req_imm_i[k*IMM_W +: IMM_W]       = tb_imm[k];
    end
  end

  always @(posedge clk_i) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      done[k] <= done[k] + int'(hs_now[k]);
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic apply_stimulus(input int id, input logic [31:0] data, input logic [2:0] imm);
    tb_data[id] = data;
    tb_imm[id]  = imm;
    issued[id]  = issued[id] + 1;
  endtask

  task automatic wait_quiet(input string name);
    bit quiet;
    quiet = 1'b0;
    for (int i = 0; i < 300 && !quiet; i++) begin
      @(posedge clk_i);
      #1;
      quiet = !m_active;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (issued[k] != done[k]) quiet = 1'b0;
      end
    end
    check_output(name, 32'(quiet), 32'd1);
  endtask

  task automatic wait_rsp_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk_i);
      #1;
      seen = rsp_valid_o;
    end
    check_output(name, 32'(seen), 32'd1);
  endtask

  // Monitor: compares outputs against the cycle-timed reference and pops the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      m_active = 1'b0;
      m_ptr    = 0;
      m_data   = '0;
      m_imm    = '0;
      sb.delete();
      hs_now   = '0;
      check_output("reset_req_ready", 32'(req_ready_o), 32'd0);
      check_output("reset_acc_start", 32'(acc_start_o), 32'd0);
      check_output("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check_output("reset_busy", 32'(busy_o), 32'd0);
      check_output("reset_rsp_data", rsp_data_o, 32'd0);
      check_output("reset_rsp_id", 32'(rsp_id_o), 32'd0);
      check_output("reset_acc_data", acc_data_o, 32'd0);
      check_output("reset_acc_imm", 32'(acc_imm_o), 32'd0);
    end else begin
      g = -1;
      for (int i = 0; i < NUM_REQ; i++) begin
        kk = (m_ptr + i) % NUM_REQ;
        if (g < 0 && req_valid_i[kk]) g = kk;
      end
      exp_ready = '0;
      if (!m_active && !flush_i && g >= 0) exp_ready[g] = 1'b1;

      check_output("req_ready", 32'(req_ready_o), 32'(exp_ready));
      check_output("busy", 32'(busy_o), 32'(m_active && cyc >= m_busy_from));
      check_output("acc_start", 32'(acc_start_o), 32'(m_active && cyc == m_busy_from));
      check_output("rsp_valid", 32'(rsp_valid_o), 32'(m_active && cyc >= m_rsp_from));
      check_output("acc_data", acc_data_o, m_data);
      check_output("acc_imm", 32'(acc_imm_o), 32'(m_imm));

      if (rsp_valid_o) begin
        if (sb.size() == 0) begin
          check_output("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          check_output("rsp_data", rsp_data_o, sb[0].data);
          check_output("rsp_id", 32'(rsp_id_o), 32'(sb[0].id));
          if (rsp_ready_i && !flush_i) void'(sb.pop_front());
        end
      end

      hs_now = req_valid_i & req_ready_o;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (hs_now[k]) hs_log.push_back('{id: k, c: cyc});
      end

      if (flush_i) begin
        if (m_active && sb.size() > 0) void'(sb.pop_back());
        m_active = 1'b0;
      end else if (m_active) begin
        if (cyc >= m_rsp_from && rsp_ready_i) m_active = 1'b0;
      end else if (g >= 0) begin
        m_active    = 1'b1;
        m_busy_from = cyc + 1;
        m_rsp_from  = cyc + 2 + int'(tb_imm[g]);
        m_data      = tb_data[g];
        m_imm       = tb_imm[g];
        m_ptr       = (g + 1) % NUM_REQ;
        sb.push_back('{id: g, data: ~tb_data[g] + 32'(cyc + 1 + int'(tb_imm[g]))});
      end
    end
  end

  initial begin
    int exp_order [4];
    exp_order = '{0, 1, 0, 1};
    for (int k = 0; k < NUM_REQ; k++) begin
      tb_data[k] = '0;
      tb_imm[k]  = '0;
    end
    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    $display("[TB] single request, requester 0, imm 0");
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    hs_log.delete();
    apply_stimulus(0, 32'h0000_00A5, 3'd0);
    wait_quiet("quiet_single");
    check_output("single_grant_id", 32'(hs_log.size() > 0 ? hs_log[0].id : -1), 32'd0);

    $display("[TB] requester 1, imm 5");
    @(posedge clk_i); #1;
    apply_stimulus(1, 32'h1234_5678, 3'd5);
    wait_quiet("quiet_imm5");

    $display("[TB] both requesters continuously valid, imm 1");
    @(posedge clk_i); #1;
    hs_log.delete();
    apply_stimulus(0, 32'h0000_1000, 3'd1);
    apply_stimulus(1, 32'h0000_2000, 3'd1);
    apply_stimulus(0, 32'h0000_1000, 3'd1);
    apply_stimulus(1, 32'h0000_2000, 3'd1);
    wait_quiet("quiet_rr");
    check_output("rr_grant_count", 32'(hs_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < hs_log.size(); i++) begin
      check_output("rr_grant_order", 32'(hs_log[i].id), 32'(exp_order[i]));
      if (i > 0) check_output("rr_grant_spacing", 32'(hs_log[i].c - hs_log[i-1].c), 32'd4);
    end

    $display("[TB] response backpressure");
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    apply_stimulus(0, 32'hCAFE_F00D, 3'd2);
    apply_stimulus(1, 32'h0BAD_BEEF, 3'd0);
    wait_rsp_valid("wait_bp_rsp");
    repeat (10) @(posedge clk_i);
    #1 rsp_ready_i = 1'b1;
    wait_quiet("quiet_bp");

    $display("[TB] flush in second BUSY cycle");
    @(posedge clk_i); #1;
    apply_stimulus(1, 32'h7777_0001, 3'd4);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clk_i);
        #1;
        seen = acc_start_o;
      end
      check_output("wait_flush_start", 32'(seen), 32'd1);
    end
    @(posedge clk_i); #1 flush_i = 1'b1;
    @(posedge clk_i); #1 flush_i = 1'b0;
    hs_log.delete();
    apply_stimulus(0, 32'h0000_00F0, 3'd0);
    apply_stimulus(1, 32'h0000_00F1, 3'd0);
    wait_quiet("quiet_flush");
    check_output("flush_next_grant", 32'(hs_log.size() > 0 ? hs_log[0].id : -1), 32'd0);

    $display("[TB] asynchronous reset in RESP");
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    apply_stimulus(0, 32'h0000_1111, 3'd1);
    wait_rsp_valid("wait_reset_rsp");
    @(posedge clk_i); #2 rst_ni = 1'b0;
    #1;
    check_output("reset_mid_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check_output("reset_mid_busy", 32'(busy_o), 32'd0);
    @(posedge clk_i); #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    hs_log.delete();
    apply_stimulus(0, 32'h0000_2222, 3'd0);
    apply_stimulus(1, 32'h0000_3333, 3'd0);
    wait_quiet("quiet_reset");
    check_output("reset_first_grant", 32'(hs_log.size() > 0 ? hs_log[0].id : -1), 32'd0);
    check_output("scoreboard_empty", 32'(sb.size()), 32'd0);

    repeat (2) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
